pipe_fetch: RTL and testbench

Instruction-fetch (IF) stage of the 5-stage pipeline. It sits directly upstream of the IF/ID pipeline register and owns the program counter. It also owns the next-PC selection with branch-delay-slot semantics and the request/acknowledge handshake to instruction memory. Each cycle it presents either a fetched instruction or a bubble (all-zero nop), together with PC+4, to the IF/ID register. The IF/ID register loads when `wpcir`=1.

---
 rtl/pipe_fetch_if.sv | 31 +++
 rtl/pipe_fetch.sv | 105 ++++++++++
 tb/tb_pipe_fetch.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/pipe_fetch_if.sv
// ============================================================================
// Module   : pipe_fetch_if
// Purpose  : Request/acknowledge fetch bus between pipe_fetch and instr memory.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface pipe_fetch_if #(
    parameter int PC_W = 8
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack;
    logic [31:0]     imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

`default_nettype wire

// File: rtl/pipe_fetch.sv
// ============================================================================
// Module   : pipe_fetch
// Purpose  : IF stage - PC, next-PC select with delay slot, imem handshake.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pipe_fetch #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  wire logic            clk,
    input  wire logic            rst,
    input  wire logic            wpcir,
    input  wire logic [1:0]      pcsrc,
    input  wire logic [PC_W-1:0] bpc,
    input  wire logic [PC_W-1:0] rpc,
    input  wire logic [PC_W-1:0] jpc,
    pipe_fetch_if.master         imem,
    output      logic [PC_W-1:0] pc,
    output      logic [PC_W-1:0] o_pc4,
    output      logic [31:0]     o_ins
);

    localparam logic [0:0] S_FETCH = 1'b0;
    localparam logic [0:0] S_HOLD  = 1'b1;

    logic [0:0]      state_q,     state_d;
    logic [PC_W-1:0] pc_q,        pc_d;
    logic [31:0]     buf_ins_q,   buf_ins_d;
    logic            rd_valid_q,  rd_valid_d;
    logic [PC_W-1:0] rd_target_q, rd_target_d;

    logic            w_fetch;
    logic            w_avail;
    logic [31:0]     w_word;
    logic            w_redir;
    logic [PC_W-1:0] w_target;
    logic [PC_W-1:0] w_pc4;
    logic [PC_W-1:0] w_next_pc;

    assign w_fetch = (state_q == S_FETCH);
    // An ack outside FETCH has no request behind it and is ignored.
    assign w_avail = (w_fetch && imem.imem_ack) || !w_fetch;
    assign w_word  = w_fetch ? imem.imem_rdata : buf_ins_q;
    assign w_pc4   = pc_q + PC_W'(4);
    assign w_redir = wpcir && (pcsrc != 2'b00);

    always_comb begin
        w_target = bpc;
        case (pcsrc)
            2'b10:   w_target = rpc;
            2'b11:   w_target = jpc;
            default: w_target = bpc;
        endcase
    end

    assign w_next_pc = w_redir    ? w_target    :
                       rd_valid_q ? rd_target_q : w_pc4;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        buf_ins_d   = buf_ins_q;
        rd_valid_d  = rd_valid_q;
        rd_target_d = rd_target_q;
        if (w_avail && wpcir) begin
            pc_d       = w_next_pc;
            rd_valid_d = 1'b0;
            state_d    = S_FETCH;
        end else if (w_fetch && imem.imem_ack && !wpcir) begin
            buf_ins_d = imem.imem_rdata;
            state_d   = S_HOLD;
        end else if (w_fetch && !imem.imem_ack && w_redir) begin
            // The in-flight word is the delay slot; remember where to go after it.
            rd_valid_d  = 1'b1;
            rd_target_d = w_target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            buf_ins_q   <= '0;
            rd_valid_q  <= 1'b0;
            rd_target_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            buf_ins_q   <= buf_ins_d;
            rd_valid_q  <= rd_valid_d;
            rd_target_q <= rd_target_d;
        end
    end

    assign imem.imem_req  = w_fetch;
    assign imem.imem_addr = pc_q;
    assign pc             = pc_q;
    assign o_pc4          = w_pc4;
    assign o_ins          = w_avail ? w_word : 32'h0;

endmodule

`default_nettype wire

// File: tb/tb_pipe_fetch.sv
// ============================================================================
// Module   : tb_pipe_fetch
// Purpose  : Directed self-checking bench for pipe_fetch with a word scoreboard.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pipe_fetch;

    logic       clk;
    logic       rst;
    logic       wpcir;
    logic [1:0] pcsrc;
    logic [7:0] bpc, rpc, jpc;
    logic [7:0] pc, o_pc4;
    logic [31:0] o_ins;

    int n_checks;
    int n_errors;
    logic bogus;
    logic [31:0] exp_q[$];

    pipe_fetch_if #(.PC_W(8)) bus ();

    pipe_fetch #(
        .PC_W     (8),
        .RESET_PC (8'h00)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .wpcir (wpcir),
        .pcsrc (pcsrc),
        .bpc   (bpc),
        .rpc   (rpc),
        .jpc   (jpc),
        .imem  (bus),
        .pc    (pc),
        .o_pc4 (o_pc4),
        .o_ins (o_ins)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [7:0] a);
        return {16'hC0DE, 8'h5A, a};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, sample outputs at the falling edge, then advance.
    task automatic cyc(input logic ack, input logic w, input logic [1:0] src,
                       input logic [7:0] ea, input logic ereq, input logic eword);
        logic [7:0]  epc4;
        logic [31:0] ew;
        bus.imem_ack   = ack;
        bus.imem_rdata = bogus ? 32'hDEADBEEF : mem(ea);
        wpcir          = w;
        pcsrc          = src;
        exp_q.push_back(eword ? mem(ea) : 32'h0);
        epc4 = ea + 8'd4;
        @(negedge clk);
        chk("imem_addr", {24'h0, bus.imem_addr}, {24'h0, ea});
        chk("pc", {24'h0, pc}, {24'h0, ea});
        chk("imem_req", {31'h0, bus.imem_req}, {31'h0, ereq});
        chk("o_pc4", {24'h0, o_pc4}, {24'h0, epc4});
        ew = exp_q.pop_front();
        chk("o_ins", o_ins, ew);
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        bogus    = 1'b0;
        rst      = 1'b1;
        wpcir    = 1'b1;
        pcsrc    = 2'b00;
        bpc = 8'h00; rpc = 8'h00; jpc = 8'h00;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'h0;
        @(posedge clk);
        #1;
        // Reset state
        cyc(1'b0, 1'b1, 2'b00, 8'h00, 1'b1, 1'b0);
        rst = 1'b0;

        // Zero-wait sequential fetch
        for (int i = 0; i < 4; i++)
            cyc(1'b1, 1'b1, 2'b00, 8'(i * 4), 1'b1, 1'b1);

        // Two-cycle latency at 0x10
        cyc(1'b0, 1'b1, 2'b00, 8'h10, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 2'b00, 8'h10, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 2'b00, 8'h10, 1'b1, 1'b1);
        for (int a = 8'h14; a <= 8'h1C; a += 4)
            cyc(1'b1, 1'b1, 2'b00, 8'(a), 1'b1, 1'b1);

        // Capture at 0x20 while stalled, hold, then release
        cyc(1'b1, 1'b0, 2'b00, 8'h20, 1'b1, 1'b1);
        bogus = 1'b1;
        bpc = 8'hEE;
        cyc(1'b1, 1'b0, 2'b01, 8'h20, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 2'b00, 8'h20, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 2'b00, 8'h20, 1'b0, 1'b1);
        bogus = 1'b0;
        for (int a = 8'h24; a <= 8'h2C; a += 4)
            cyc(1'b1, 1'b1, 2'b00, 8'(a), 1'b1, 1'b1);

        // Branch while fetch of 0x30 waits: delay slot issues, then target
        bpc = 8'h80;
        cyc(1'b0, 1'b1, 2'b01, 8'h30, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 2'b00, 8'h30, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 2'b00, 8'h30, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 2'b00, 8'h80, 1'b1, 1'b1);

        // Pending rpc overwritten by live jpc; stalled pcsrc ignored
        rpc = 8'h60;
        cyc(1'b0, 1'b1, 2'b10, 8'h84, 1'b1, 1'b0);
        jpc = 8'h90;
        cyc(1'b0, 1'b1, 2'b11, 8'h84, 1'b1, 1'b0);
        bpc = 8'hEE;
        cyc(1'b0, 1'b0, 2'b01, 8'h84, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 2'b00, 8'h84, 1'b1, 1'b1);

        // Zero-wait jumps and address wrap
        jpc = 8'h08;
        cyc(1'b1, 1'b1, 2'b11, 8'h90, 1'b1, 1'b1);
        jpc = 8'h40;
        cyc(1'b1, 1'b1, 2'b11, 8'h08, 1'b1, 1'b1);
        jpc = 8'hFC;
        cyc(1'b1, 1'b1, 2'b11, 8'h40, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 2'b00, 8'hFC, 1'b1, 1'b1);
        bpc = 8'h50;
        cyc(1'b1, 1'b1, 2'b01, 8'h00, 1'b1, 1'b1);

        // Reset coinciding with an ack at 0x50 drops that word
        rst = 1'b1;
        cyc(1'b1, 1'b1, 2'b00, 8'h50, 1'b1, 1'b1);
        rst = 1'b0;
        cyc(1'b0, 1'b1, 2'b00, 8'h00, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 2'b00, 8'h00, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 2'b00, 8'h04, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
